// File: rtl/shift_out_serializer_pkg.sv
// rtl/shift_out_serializer_pkg.sv - shared types and defaults for the shift-out serializer
package shift_out_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_e;

   localparam int DEFAULT_WIDTH  = 10;
   localparam int DEFAULT_PERIOD = 4194304;

endpackage

// File: rtl/shift_out_serializer_if.sv
// rtl/shift_out_serializer_if.sv - button/switch inputs and serial/status outputs of the serializer
interface shift_out_serializer_if
   import shift_out_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) ();

   logic             start_n;
   logic [WIDTH-1:0] data;
   logic             serial_out;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] remaining;

   modport master (
      output start_n, data,
      input  serial_out, busy, done, remaining
   );

   modport slave (
      input  start_n, data,
      output serial_out, busy, done, remaining
   );

endinterface

// File: rtl/shift_out_serializer_timer.sv
// rtl/shift_out_serializer_timer.sv - restartable 0..PERIOD-1 counter with a wrap strobe
module restartable_timer
   import shift_out_pkg::*;
#(
   parameter int PERIOD = DEFAULT_PERIOD
) (
   input  logic clock,
   input  logic reset_n,
   input  logic clear,
   input  logic enable,
   output logic strobe
);

   localparam int            TW   = (PERIOD > 1) ? $clog2(PERIOD) : 1;
   localparam logic [TW-1:0] LAST = TW'(PERIOD - 1);

   logic [TW-1:0] count_q, count_d;

   // Explicit compare keeps non-power-of-two periods exact.
   assign strobe = enable && (count_q == LAST);

   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (enable) begin
         count_d = (count_q == LAST) ? '0 : count_q + 1'b1;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/shift_out_serializer.sv
// rtl/shift_out_serializer.sv - captures a word on a button press and shifts it out LSB-first
module shift_out_serializer
   import shift_out_pkg::*;
#(
   parameter int WIDTH  = DEFAULT_WIDTH,
   parameter int PERIOD = DEFAULT_PERIOD
) (
   input  logic                   clock,
   input  logic                   reset_n,
   shift_out_serializer_if.slave  bus
);

   localparam int            CW       = $clog2(WIDTH);
   localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH - 1);

   logic             s1_q, s1_d, s2_q, s2_d, prev_q, prev_d;
   state_e           state_q, state_d;
   logic             serial_q, serial_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [WIDTH-1:0] remaining_q, remaining_d;
   logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
   logic             start_pulse;
   logic             timer_clear;
   logic             strobe;

   restartable_timer #(.PERIOD(PERIOD)) u_timer (
      .clock   (clock),
      .reset_n (reset_n),
      .clear   (timer_clear),
      .enable  (state_q == SHIFT),
      .strobe  (strobe)
   );

   // Falling edge of the synchronized button, so a long hold yields one pulse.
   assign start_pulse = prev_q & ~s2_q;

   always_comb begin
      s1_d        = bus.start_n;
      s2_d        = s1_q;
      prev_d      = s2_q;
      state_d     = state_q;
      serial_d    = serial_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      remaining_d = remaining_q;
      bit_cnt_d   = bit_cnt_q;
      timer_clear = 1'b0;
      case (state_q)
         IDLE: begin
            if (start_pulse) begin
               remaining_d = bus.data;
               serial_d    = bus.data[0];
               bit_cnt_d   = CNT_LOAD;
               timer_clear = 1'b1;
               busy_d      = 1'b1;
               state_d     = SHIFT;
            end
         end
         SHIFT: begin
            if (strobe) begin
               if (bit_cnt_q != '0) begin
                  remaining_d = {1'b0, remaining_q[WIDTH-1:1]};
                  serial_d    = remaining_q[1];
                  bit_cnt_d   = bit_cnt_q - 1'b1;
               end else begin
                  state_d     = IDLE;
                  busy_d      = 1'b0;
                  done_d      = 1'b1;
                  serial_d    = 1'b0;
                  remaining_d = '0;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         s1_q        <= 1'b1;
         s2_q        <= 1'b1;
         prev_q      <= 1'b1;
         state_q     <= IDLE;
         serial_q    <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         remaining_q <= '0;
         bit_cnt_q   <= '0;
      end else begin
         s1_q        <= s1_d;
         s2_q        <= s2_d;
         prev_q      <= prev_d;
         state_q     <= state_d;
         serial_q    <= serial_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         remaining_q <= remaining_d;
         bit_cnt_q   <= bit_cnt_d;
      end
   end

   assign bus.serial_out = serial_q;
   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.remaining  = remaining_q;

endmodule

// File: tb/tb_shift_out_serializer.sv
// tb/tb_shift_out_serializer.sv - directed table-driven bench for shift_out_serializer
module tb_shift_out_serializer;
   import shift_out_pkg::*;

   localparam int W = 10;
   localparam int P = 4;

   typedef struct {
      logic [W-1:0] data;
      logic [W-1:0] stream;   // leftmost bit is the first bit on the line
      int           hold;
      int           press_at;
      logic [W-1:0] next_d;
   } vec_t;

   logic clock;
   logic reset_n;
   int   checks;
   int   errors;
   int   el;
   int   hold_lim;

   shift_out_serializer_if #(.WIDTH(W)) bus ();

   shift_out_serializer #(.WIDTH(W), .PERIOD(P)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
      el++;
      if (el == hold_lim) bus.start_n = 1'b1;
   endtask

   task automatic chk_idle(input string name);
      chk({name, "_serial"}, 32'(bus.serial_out), 32'd0);
      chk({name, "_busy"}, 32'(bus.busy), 32'd0);
      chk({name, "_done"}, 32'(bus.done), 32'd0);
      chk({name, "_rem"}, 32'(bus.remaining), 32'd0);
   endtask

   task automatic run_transfer(input vec_t v);
      el       = 0;
      hold_lim = v.hold;
      bus.data    = v.data;
      bus.start_n = 1'b0;
      tick();
      chk("lat_k", 32'(bus.busy), 32'd0);
      tick();
      chk("lat_k1", 32'(bus.busy), 32'd0);
      tick();
      chk("busy_rise", 32'(bus.busy), 32'd1);
      chk("load_rem", 32'(bus.remaining), 32'(v.data));
      bus.data = ~v.data;
      for (int j = 0; j < W * P; j++) begin
         chk("serial", 32'(bus.serial_out), 32'(v.stream[W-1-j/P]));
         chk("busy_hold", 32'(bus.busy), 32'd1);
         chk("no_done", 32'(bus.done), 32'd0);
         chk("rem_lsb", 32'(bus.remaining[0]), 32'(bus.serial_out));
         if (j == v.press_at) begin
            bus.start_n = 1'b0;
            bus.data    = v.next_d;
         end
         if (j == v.press_at + 1) bus.start_n = 1'b1;
         tick();
      end
      chk("done_pulse", 32'(bus.done), 32'd1);
      chk("busy_fall", 32'(bus.busy), 32'd0);
      chk("end_serial", 32'(bus.serial_out), 32'd0);
      chk("end_rem", 32'(bus.remaining), 32'd0);
      tick();
      chk("done_one", 32'(bus.done), 32'd0);
      chk("next_busy", 32'(bus.busy), (v.press_at == W * P - 2) ? 32'd1 : 32'd0);
      if (v.press_at != W * P - 2) begin
         while (el < v.hold) begin
            tick();
            chk("hold_idle", 32'(bus.busy), 32'd0);
         end
      end
   endtask

   vec_t tbl[7];

   initial begin
      int n;
      checks = 0;
      errors = 0;
      el = 0;
      hold_lim = -1;

      tbl[0] = '{10'b1000000101, 10'b1010000001, 2,   -1, 10'h000};
      tbl[1] = '{10'h000,        10'h000,        2,   -1, 10'h000};
      tbl[2] = '{10'h3FF,        10'h3FF,        2,   -1, 10'h000};
      tbl[3] = '{10'b1010101010, 10'b0101010101, 200, -1, 10'h000};
      tbl[4] = '{10'b0000000001, 10'b1000000000, 2,   20, 10'h2F0};
      tbl[5] = '{10'b0110011001, 10'b1001100110, 2,   37, 10'h155};
      tbl[6] = '{10'b1000000101, 10'b1010000001, 2,   38, 10'h2C3};

      // Reset held: button activity must not move any output.
      reset_n     = 1'b0;
      bus.start_n = 1'b1;
      bus.data    = 10'h3FF;
      for (int i = 0; i < 8; i++) begin
         bus.start_n = i[0];
         tick();
         chk_idle("rst");
      end
      bus.start_n = 1'b1;
      tick();
      reset_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk_idle("post_rst");
      end

      for (int i = 0; i < 7; i++) begin
         run_transfer(tbl[i]);
         if (i == 6) begin
            chk("b2b_rem", 32'(bus.remaining), 32'(10'h2C3));
            chk("b2b_serial", 32'(bus.serial_out), 32'd1);
            n = 0;
            while (bus.done !== 1'b1 && n < 60) begin
               tick();
               n++;
            end
            chk("b2b_len", 32'(n), 32'd40);
         end
         bus.start_n = 1'b1;
         for (int g = 0; g < 8; g++) begin
            tick();
            chk("gap_idle", 32'(bus.busy), 32'd0);
         end
      end

      // Abort during bit 5: asynchronous clear, no done afterwards.
      el = 0;
      hold_lim = 2;
      bus.data    = 10'b1000000101;
      bus.start_n = 1'b0;
      for (int i = 0; i < 3 + 21; i++) tick();
      chk("pre_abort_busy", 32'(bus.busy), 32'd1);
      reset_n = 1'b0;
      #1;
      chk_idle("abort");
      tick();
      tick();
      chk_idle("abort_hold");
      reset_n = 1'b1;
      for (int i = 0; i < 45; i++) begin
         tick();
         chk("abort_no_done", 32'(bus.done), 32'd0);
         chk("abort_no_busy", 32'(bus.busy), 32'd0);
      end
      run_transfer('{10'b0000110011, 10'b1100110000, 2, -1, 10'h000});
      for (int g = 0; g < 4; g++) begin
         tick();
         chk_idle("final_idle");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/shift_out_serializer.md
# shift_out_serializer

Parallel-in, serial-out companion to the board's serial-in shift register. On a button press it captures a WIDTH-bit word from the switches and shifts it out LSB-first on one line, one bit per timer period, with busy/done status and the remaining bits mirrored for display on the LEDs. It sits at board top level between the switch/key inputs and the LED or GPIO outputs, and has its own restartable period timer.

## Interface
- WIDTH, 10, word length in bits (≥2)
- PERIOD, 4194304, clock cycles each bit is held (≥2; about 0.08 s at 50 MHz)
- clock  in  1  50 MHz clock, all logic on the rising edge
- reset_n  in  1  asynchronous, active-low reset
- start_n  in  1  raw active-low push button, asynchronous to clock
- data  in  WIDTH  parallel word, sampled only on an accepted start
- serial_out  out  1  current serial bit
- busy  out  1  high while a word is being shifted out
- done  out  1  one-cycle pulse when the last bit period ends
- remaining  out  WIDTH  shift register contents; bit 0 equals serial_out

## Operation
- Input conditioning: start_n passes through two synchronizer flops (s1, s2), then an edge register prev.
  - s1, s2 and prev reset to 1.
  - start_pulse = prev & ~s2, so one pulse per press regardless of hold time.
- States are IDLE and SHIFT. Reset enters IDLE.
- IDLE with start_pulse:
  - remaining ← data, serial_out ← data[0]
  - bit_cnt ← WIDTH−1, timer cleared to 0, busy ← 1
  - go to SHIFT
- IDLE without start_pulse: all outputs hold their reset values.
- SHIFT: the timer counts 0..PERIOD−1 and wraps. The wrap cycle is the strobe.
  - Strobe with bit_cnt ≠ 0: remaining ← {1'b0, remaining[WIDTH−1:1]}, serial_out ← remaining[1], bit_cnt decrements.
  - Strobe with bit_cnt = 0: go to IDLE, busy ← 0, done ← 1 for one cycle, serial_out ← 0, remaining ← 0.
- start_pulse in SHIFT, including the final strobe cycle, is dropped and never queued.
- data changes during SHIFT have no effect.
- Reset values: serial_out 0, busy 0, done 0, remaining 0, bit_cnt 0, timer 0.
- Assertion of reset_n mid-transfer aborts immediately and asynchronously. No done pulse is produced.
- Width rules:
  - timer is $clog2(PERIOD) bits and compares against PERIOD−1; it is not a free power-of-two wrap.
  - bit_cnt is $clog2(WIDTH) bits.

## Timing
- Press latency: if start_n is low at rising edge k, start_pulse is high between edges k+1 and k+2. busy and the first serial_out bit are registered at edge k+2.
- Each bit is held exactly PERIOD cycles. A word occupies WIDTH×PERIOD cycles from load to busy falling.
- done rises on the same edge busy falls and lasts one cycle.
- Back-to-back operation: the earliest new load is the edge after busy falls, and only if start_pulse occurs then.
- All outputs are registered, with no combinational path from inputs to outputs.

## Structure
- Package shift_out_pkg:
  - state enum {IDLE, SHIFT}
  - DEFAULT_WIDTH = 10
  - DEFAULT_PERIOD = 4194304
- Sub-module restartable_timer (parameter PERIOD; ports clock, reset_n, clear, enable, strobe):
  - clear has priority and zeroes the count.
  - strobe is combinational on count == PERIOD−1 while enabled.
- Top body contains the synchronizer, edge detect, FSM, shift register and bit counter.

## Test plan
All scenarios use WIDTH=10, PERIOD=4.
- Reset: hold reset_n low, toggle start_n → serial_out, busy, done = 0 and remaining = 0 throughout.
- Basic transfer: data=10'b1000000101, press start_n → busy rises on the 3rd edge after sampling low. serial_out is 1,0,1,0,0,0,0,0,0,1, each held 4 cycles. done pulses once at cycle 40 after load, and busy falls on the same edge.
- Hold and re-press: hold start_n low 200 cycles → exactly one 40-cycle transfer. A second press at cycle 20 of a transfer → ignored, and done occurs once.
- Mid-transfer reset: pulse reset_n low during bit 5 → all outputs 0 asynchronously, no done. The next press transfers the newly sampled data from bit 0.
- Extremes: data=0 → busy for 40 cycles with serial_out 0. data=10'h3FF → serial_out 1 for exactly 40 cycles, then 0.
- Boundary press: start_pulse coincident with the final strobe → dropped, idle afterwards. A press whose pulse lands one cycle after done → new transfer loads on that edge.
